cache_fsm_l2b: RTL and testbench
================================

CACHE_FSM_L2B -- requirements
Module: cache_fsm_l2b

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDRESS_WIDTH, 32, request address width; bits [31:30] carry processor ID and are ignored.
- DATA_WIDTH, 32, word width.
- BLOCK_WIDTH, 128, block width; 4 words per block.
- NUM_SETS, 64, direct-mapped sets.
- Address fields: offset [3:0], word select [3:2], index [9:4], tag [29:10].
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-high reset, named clk and reset. Ports, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
- read_from_L2b_request  in  1  L1 block read.
- write_to_L2b_request  in  1  L1 word write (inclusion).
- write_back_to_L2b_request  in  1  L1 dirty-block write-back.
- cache_L2b_memory_address  in  32  request address.
- cache_1b_write_data_to_L2b  in  32  word write data.
- write_back_to_L2b_data  in  128  write-back block.
- L2b_ready  out  1  read-done pulse.
- write_data_to_L1b_from_L2b  out  128  read block; valid with L2b_ready.
- write_to_L2b_verified  out  1  word-write-done pulse.
- write_back_to_L2b_verified  out  1  write-back-done pulse.
- mem_read_request  out  1  memory block read.
- mem_write_request  out  1  memory block write.
- mem_address  out  32  block-aligned memory address.
- mem_write_data  out  128  eviction block.
- mem_read_data  in  128  fill block; valid with mem_ready.
- mem_ready  in  1  memory completion for the current request.
- L2b_cache_hit  out  1  lookup hit pulse.
- L2b_cache_miss  out  1  lookup miss pulse.

Function
REQ-003 States SHALL be IDLE, LOOKUP, EVICT, FILL, RESPOND; per-set storage SHALL be valid, dirty, tag and block.
REQ-004 Requests SHALL be sampled only in IDLE. Priority: write-back > word write > read. Kind, address, word data and block data are latched on that edge, then the FSM goes to LOOKUP. Requests are level signals held until acknowledged.
REQ-005 LOOKUP SHALL pulse L2b_cache_hit if valid[index] and tag match, otherwise L2b_cache_miss, for exactly one cycle.
REQ-006 On hit, the FSM SHALL go to RESPOND.
REQ-007 On miss with the victim valid and dirty, the FSM SHALL go to EVICT.
REQ-008 On any other miss, the FSM SHALL go to FILL for read and word write, and to RESPOND for write-back (full-block allocate, no memory read).
REQ-009 EVICT SHALL hold mem_write_request=1, mem_address={2'b00,victim tag,index,4'h0} and mem_write_data=victim block until mem_ready. It then clears dirty and goes to FILL, or to RESPOND for write-back.
REQ-010 FILL SHALL hold mem_read_request=1, mem_address={latched addr[31:4],4'h0} until mem_ready. It then stores mem_read_data, sets tag, valid=1, dirty=0, and goes to RESPOND.
REQ-011 RESPOND SHALL complete the latched request, assert exactly one acknowledge for exactly one cycle, and return to IDLE.
- Read: drives the block and pulses L2b_ready.
- Word write: merges the word at bits [word*32 +: 32], sets dirty=1, pulses write_to_L2b_verified.
- Write-back: stores the block, tag and valid=1, sets dirty=1, pulses write_back_to_L2b_verified.
REQ-012 Hit latency SHALL be 2 cycles: request sampled at edge E0, acknowledge high between E1 and E2.
REQ-013 mem_read_request and mem_write_request SHALL never be high together; both SHALL be low outside FILL/EVICT.
REQ-014 A request still high in the cycle after RESPOND SHALL NOT be re-accepted unless it is still high at the next IDLE sample edge.
REQ-015 mem_ready outside EVICT/FILL SHALL be ignored.

Reset
REQ-016 Reset SHALL immediately force IDLE, clear all valid/dirty/tag/block storage, and drive every output to 0, including mid-EVICT/FILL; memory requests drop asynchronously.

Verification
REQ-017 Cold read: read 0x0000_0010, mem_ready with 128'h4444_3333_2222_1111 -> miss pulse, mem_read at 0x0000_0010, L2b_ready with that block.
REQ-018 Read hit: repeat the read of 0x0000_0010 -> hit pulse, L2b_ready 2 cycles after sampling, no memory request.
REQ-019 Word write: write 0xDEAD_BEEF to 0x0000_0018 -> write_to_L2b_verified; the next read returns bits[95:64]=0xDEAD_BEEF, other words unchanged.
REQ-020 Dirty eviction: then read 0x0000_0410 -> mem_write at 0x0000_0010 carrying the merged block, then mem_read at 0x0000_0410, then L2b_ready.
REQ-021 Arbitration: read and write-back to clean set 0x0000_0020 raised on the same edge -> write-back served first with no memory traffic; the read served next as a hit returning the written-back block.
REQ-022 Reset mid-FILL: assert reset while mem_read_request=1 -> request low immediately; a subsequent read of the same address misses.

Source files
------------

// File: rtl/cache_fsm_l2b.sv
// Direct-mapped, write-back L2 bank controller serving L1 block reads, word
// writes and dirty-block write-backs against a block-wide memory port.
module cache_fsm_l2b #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int NUM_SETS      = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_from_L2b_request,
  input  logic                     write_to_L2b_request,
  input  logic                     write_back_to_L2b_request,
  input  logic [ADDRESS_WIDTH-1:0] cache_L2b_memory_address,
  input  logic [DATA_WIDTH-1:0]    cache_1b_write_data_to_L2b,
  input  logic [BLOCK_WIDTH-1:0]   write_back_to_L2b_data,
  output logic                     L2b_ready,
  output logic [BLOCK_WIDTH-1:0]   write_data_to_L1b_from_L2b,
  output logic                     write_to_L2b_verified,
  output logic                     write_back_to_L2b_verified,
  output logic                     mem_read_request,
  output logic                     mem_write_request,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [BLOCK_WIDTH-1:0]   mem_write_data,
  input  logic [BLOCK_WIDTH-1:0]   mem_read_data,
  input  logic                     mem_ready,
  output logic                     L2b_cache_hit,
  output logic                     L2b_cache_miss
);

  localparam int OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int WORD_BITS   = $clog2(BLOCK_WIDTH / DATA_WIDTH);
  localparam int BYTE_BITS   = OFFSET_BITS - WORD_BITS;
  localparam int TAG_BITS    = ADDRESS_WIDTH - 2 - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESPOND} state_e;
  typedef enum logic [1:0] {REQ_READ, REQ_WRITE, REQ_WB} kind_e;

  state_e                   state_q, state_d;
  kind_e                    kind_q, kind_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wordData_q, wordData_d;
  logic [BLOCK_WIDTH-1:0]   wbBlock_q, wbBlock_d;

  logic                     valid_q [NUM_SETS];
  logic                     dirty_q [NUM_SETS];
  logic [TAG_BITS-1:0]      tag_q   [NUM_SETS];
  logic [BLOCK_WIDTH-1:0]   block_q [NUM_SETS];

  logic [INDEX_BITS-1:0]    setIdx;
  logic [TAG_BITS-1:0]      reqTag;
  logic [WORD_BITS-1:0]     wordSel;
  logic [BLOCK_WIDTH-1:0]   curBlock;
  logic [BLOCK_WIDTH-1:0]   mergedBlock;
  logic [BLOCK_WIDTH-1:0]   newBlock;
  logic                     tagHit;
  logic                     evictDone;
  logic                     fillWe;
  logic                     respondWe;
  logic                     unused_byte_offset;

  assign setIdx   = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign reqTag   = addr_q[OFFSET_BITS + INDEX_BITS +: TAG_BITS];
  assign wordSel  = addr_q[BYTE_BITS +: WORD_BITS];
  assign curBlock = block_q[setIdx];
  assign tagHit   = valid_q[setIdx] && (tag_q[setIdx] == reqTag);
  assign unused_byte_offset = ^addr_q[BYTE_BITS-1:0];

  always_comb begin
    mergedBlock = curBlock;
    mergedBlock[32'(wordSel) * DATA_WIDTH +: DATA_WIDTH] = wordData_q;
    newBlock = (kind_q == REQ_WB) ? wbBlock_q : mergedBlock;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kind_q     <= REQ_READ;
      addr_q     <= '0;
      wordData_q <= '0;
      wbBlock_q  <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      wordData_q <= wordData_d;
      wbBlock_q  <= wbBlock_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    wordData_d = wordData_q;
    wbBlock_d  = wbBlock_q;
    L2b_ready                  = 1'b0;
    write_data_to_L1b_from_L2b = '0;
    write_to_L2b_verified      = 1'b0;
    write_back_to_L2b_verified = 1'b0;
    mem_read_request           = 1'b0;
    mem_write_request          = 1'b0;
    mem_address                = '0;
    mem_write_data             = '0;
    L2b_cache_hit              = 1'b0;
    L2b_cache_miss             = 1'b0;
    evictDone                  = 1'b0;
    fillWe                     = 1'b0;
    respondWe                  = 1'b0;

    case (state_q)
      IDLE: begin
        if (write_back_to_L2b_request || write_to_L2b_request || read_from_L2b_request) begin
          if (write_back_to_L2b_request)  kind_d = REQ_WB;
          else if (write_to_L2b_request)  kind_d = REQ_WRITE;
          else                            kind_d = REQ_READ;
          addr_d     = cache_L2b_memory_address;
          wordData_d = cache_1b_write_data_to_L2b;
          wbBlock_d  = write_back_to_L2b_data;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (tagHit) begin
          L2b_cache_hit = 1'b1;
          state_d       = RESPOND;
        end else begin
          L2b_cache_miss = 1'b1;
          if (valid_q[setIdx] && dirty_q[setIdx]) state_d = EVICT;
          else if (kind_q == REQ_WB)              state_d = RESPOND;
          else                                    state_d = FILL;
        end
      end
      // Victim address is rebuilt from the stored tag; processor-ID bits are zero.
      EVICT: begin
        mem_write_request = 1'b1;
        mem_address       = {2'b00, tag_q[setIdx], setIdx, {OFFSET_BITS{1'b0}}};
        mem_write_data    = curBlock;
        if (mem_ready) begin
          evictDone = 1'b1;
          state_d   = (kind_q == REQ_WB) ? RESPOND : FILL;
        end
      end
      FILL: begin
        mem_read_request = 1'b1;
        mem_address      = {addr_q[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (mem_ready) begin
          fillWe  = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
        case (kind_q)
          REQ_READ: begin
            L2b_ready                  = 1'b1;
            write_data_to_L1b_from_L2b = curBlock;
          end
          REQ_WRITE: begin
            write_to_L2b_verified = 1'b1;
            respondWe             = 1'b1;
          end
          default: begin
            write_back_to_L2b_verified = 1'b1;
            respondWe                  = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Word writes and write-backs both leave the set dirty; a fill leaves it clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= 1'b0;
        dirty_q[s] <= 1'b0;
        tag_q[s]   <= '0;
        block_q[s] <= '0;
      end
    end else if (evictDone) begin
      dirty_q[setIdx] <= 1'b0;
    end else if (fillWe) begin
      block_q[setIdx] <= mem_read_data;
      tag_q[setIdx]   <= reqTag;
      valid_q[setIdx] <= 1'b1;
      dirty_q[setIdx] <= 1'b0;
    end else if (respondWe) begin
      block_q[setIdx] <= newBlock;
      tag_q[setIdx]   <= reqTag;
      valid_q[setIdx] <= 1'b1;
      dirty_q[setIdx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_fsm_l2b.sv
// Table-driven bench for cache_fsm_l2b: each record is one L1 request with its
// expected lookup result, memory traffic and returned block.
module tb_cache_fsm_l2b;

  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_WB    = 2;
  localparam int NUM_VECS = 17;

  localparam logic [127:0] B1  = 128'h4444_3333_2222_1111;
  localparam logic [127:0] B2  = 128'h0000_0000_DEAD_BEEF_4444_3333_2222_1111;
  localparam logic [127:0] B3  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] B4  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] B5  = 128'hFEED_FACE_0000_0001_FEED_FACE_0000_0002;
  localparam logic [127:0] B5A = 128'h1234_5678_0000_0001_FEED_FACE_0000_0002;
  localparam logic [127:0] B5B = 128'h1234_5678_0000_0001_FEED_FACE_A5A5_A5A5;
  localparam logic [127:0] B6  = 128'h6666_6666_5555_5555_4444_4444_3333_3333;
  localparam logic [127:0] B6M = 128'hCAFE_F00D_5555_5555_4444_4444_3333_3333;
  localparam logic [127:0] B7  = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
  localparam logic [127:0] B8  = 128'h8888_8888_8888_8888_0000_0000_0000_0001;
  localparam logic [127:0] B9  = 128'h9999_9999_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC;

  logic         clk = 1'b0;
  logic         reset;
  logic         readReq, writeReq, wbReq;
  logic [31:0]  reqAddr;
  logic [31:0]  reqWord;
  logic [127:0] reqBlock;
  logic         l2Ready;
  logic [127:0] l1Data;
  logic         writeVerified, wbVerified;
  logic         memRd, memWr;
  logic [31:0]  memAddr;
  logic [127:0] memWrData;
  logic [127:0] memRdData;
  logic         memReady;
  logic         cacheHit, cacheMiss;

  int testsRun = 0;
  int testsFailed = 0;
  bit holdReady = 1'b0;

  typedef struct {
    int           kind;
    bit           alsoRead;
    logic [31:0]  addr;
    logic [31:0]  wordData;
    logic [127:0] blockData;
    logic [127:0] fillData;
    bit           expHit;
    bit           expWr;
    logic [31:0]  expWrAddr;
    logic [127:0] expWrData;
    bit           expRd;
    logic [31:0]  expRdAddr;
    logic [127:0] expBlock;
  } vec_t;

  vec_t vecs [NUM_VECS];

  always #5 clk = ~clk;

  cache_fsm_l2b dut (
    .clk                        (clk),
    .reset                      (reset),
    .read_from_L2b_request      (readReq),
    .write_to_L2b_request       (writeReq),
    .write_back_to_L2b_request  (wbReq),
    .cache_L2b_memory_address   (reqAddr),
    .cache_1b_write_data_to_L2b (reqWord),
    .write_back_to_L2b_data     (reqBlock),
    .L2b_ready                  (l2Ready),
    .write_data_to_L1b_from_L2b (l1Data),
    .write_to_L2b_verified      (writeVerified),
    .write_back_to_L2b_verified (wbVerified),
    .mem_read_request           (memRd),
    .mem_write_request          (memWr),
    .mem_address                (memAddr),
    .mem_write_data             (memWrData),
    .mem_read_data              (memRdData),
    .mem_ready                  (memReady),
    .L2b_cache_hit              (cacheHit),
    .L2b_cache_miss             (cacheMiss)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one request from a negedge, plays memory with a 2-cycle ready delay,
  // and returns on the negedge after the acknowledge once the bank is quiet again.
  task automatic applyStimulus(input string name, input vec_t v);
    int cycles = 0, rdWait = 0, wrWait = 0, hits = 0, misses = 0, ackCycle = 0;
    bit sawRd = 0, sawWr = 0, both = 0, acked = 0;
    logic [31:0]  rdAddr = '0, wrAddr = '0;
    logic [127:0] wrData = '0, ackBlock = '0;
    logic [2:0]   ackSeen = '0, ackExp;
    ackExp   = {v.kind == K_READ, v.kind == K_WRITE, v.kind == K_WB};
    reqAddr  = v.addr;
    reqWord  = v.wordData;
    reqBlock = v.blockData;
    readReq  = (v.kind == K_READ) || v.alsoRead;
    writeReq = (v.kind == K_WRITE);
    wbReq    = (v.kind == K_WB);
    while (!acked && cycles < 40) begin
      @(negedge clk);
      cycles++;
      memReady = holdReady;
      if (cacheHit) hits++;
      if (cacheMiss) misses++;
      if (memRd && memWr) both = 1;
      if (memWr) begin
        if (!sawWr) begin
          sawWr  = 1;
          wrAddr = memAddr;
          wrData = memWrData;
        end
        wrWait++;
        if (wrWait >= 2) memReady = 1'b1;
      end
      if (memRd) begin
        if (!sawRd) begin
          sawRd  = 1;
          rdAddr = memAddr;
        end
        rdWait++;
        memRdData = v.fillData;
        if (rdWait >= 2) memReady = 1'b1;
      end
      if (l2Ready || writeVerified || wbVerified) begin
        acked    = 1;
        ackCycle = cycles;
        ackSeen  = {l2Ready, writeVerified, wbVerified};
        ackBlock = l1Data;
        writeReq = 1'b0;
        wbReq    = 1'b0;
        if (v.kind == K_READ) readReq = 1'b0;
      end
    end
    checkOutput({name, " acked"}, 128'(acked), 128'(1));
    checkOutput({name, " hitPulses"}, 128'(hits), 128'(v.expHit ? 1 : 0));
    checkOutput({name, " missPulses"}, 128'(misses), 128'(v.expHit ? 0 : 1));
    checkOutput({name, " memWrSeen"}, 128'(sawWr), 128'(v.expWr));
    if (v.expWr) begin
      checkOutput({name, " memWrAddr"}, 128'(wrAddr), 128'(v.expWrAddr));
      checkOutput({name, " memWrData"}, wrData, v.expWrData);
    end
    checkOutput({name, " memRdSeen"}, 128'(sawRd), 128'(v.expRd));
    if (v.expRd) checkOutput({name, " memRdAddr"}, 128'(rdAddr), 128'(v.expRdAddr));
    checkOutput({name, " memBothHigh"}, 128'(both), 128'(0));
    checkOutput({name, " ackKind"}, 128'(ackSeen), 128'(ackExp));
    if (v.kind == K_READ) checkOutput({name, " block"}, ackBlock, v.expBlock);
    if (v.expHit) checkOutput({name, " hitLatency"}, 128'(ackCycle), 128'(2));
    @(negedge clk);
    memReady = holdReady;
    checkOutput({name, " quietAfterAck"},
                128'({l2Ready, writeVerified, wbVerified, cacheHit, cacheMiss, memRd, memWr}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t extra;
    bit   fillSeen;

    //          kind     aR    addr           word          block fill  hit wr  wrAddr   wrData rd  rdAddr         expBlock
    vecs[0]  = '{K_READ,  1'b0, 32'h0000_0010, 32'h0,        '0,   B1,   0,  0,  32'h0,   '0,    1,  32'h0000_0010, B1};
    vecs[1]  = '{K_READ,  1'b0, 32'h0000_0010, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B1};
    vecs[2]  = '{K_WRITE, 1'b0, 32'h0000_0018, 32'hDEAD_BEEF,'0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         '0};
    vecs[3]  = '{K_READ,  1'b0, 32'h0000_0010, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B2};
    vecs[4]  = '{K_READ,  1'b0, 32'h0000_0410, 32'h0,        '0,   B3,   0,  1,  32'h10,  B2,    1,  32'h0000_0410, B3};
    vecs[5]  = '{K_READ,  1'b0, 32'h0000_0014, 32'h0,        '0,   B4,   0,  0,  32'h0,   '0,    1,  32'h0000_0010, B4};
    vecs[6]  = '{K_WB,    1'b1, 32'h0000_0020, 32'h0,        B5,   '0,   0,  0,  32'h0,   '0,    0,  32'h0,         '0};
    vecs[7]  = '{K_READ,  1'b0, 32'h0000_0020, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B5};
    vecs[8]  = '{K_WRITE, 1'b0, 32'h0000_003C, 32'hCAFE_F00D,'0,   B6,   0,  0,  32'h0,   '0,    1,  32'h0000_0030, '0};
    vecs[9]  = '{K_READ,  1'b0, 32'h0000_0034, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B6M};
    vecs[10] = '{K_WB,    1'b0, 32'h0000_0430, 32'h0,        B7,   '0,   0,  1,  32'h30,  B6M,   0,  32'h0,         '0};
    vecs[11] = '{K_READ,  1'b0, 32'h0000_0438, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B7};
    vecs[12] = '{K_READ,  1'b0, 32'hC000_0024, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B5};
    vecs[13] = '{K_WRITE, 1'b0, 32'h0000_002C, 32'h1234_5678,'0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         '0};
    vecs[14] = '{K_READ,  1'b0, 32'h0000_0020, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B5A};
    vecs[15] = '{K_WRITE, 1'b0, 32'h0000_0020, 32'hA5A5_A5A5,'0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         '0};
    vecs[16] = '{K_READ,  1'b0, 32'h0000_0020, 32'h0,        '0,   '0,   1,  0,  32'h0,   '0,    0,  32'h0,         B5B};

    reset     = 1'b0;
    readReq   = 1'b0;
    writeReq  = 1'b0;
    wbReq     = 1'b0;
    reqAddr   = '0;
    reqWord   = '0;
    reqBlock  = '0;
    memRdData = '0;
    memReady  = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset flags",
                128'({l2Ready, writeVerified, wbVerified, cacheHit, cacheMiss, memRd, memWr}), 128'(0));
    checkOutput("reset memAddr", 128'(memAddr), 128'(0));
    checkOutput("reset l1Data", l1Data, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NUM_VECS; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // mem_ready held high through IDLE and a hit must not disturb anything.
    holdReady = 1'b1;
    extra = '{K_READ, 1'b0, 32'h0000_0020, 32'h0, '0, '0, 1, 0, 32'h0, '0, 0, 32'h0, B5B};
    applyStimulus("strayReady", extra);
    holdReady = 1'b0;
    memReady  = 1'b0;

    // Reset while a fill is outstanding drops the memory request at once.
    reqAddr  = 32'h0000_0050;
    readReq  = 1'b1;
    fillSeen = 1'b0;
    for (int c = 0; c < 10 && !fillSeen; c++) begin
      @(negedge clk);
      if (memRd) fillSeen = 1'b1;
    end
    checkOutput("rstFill reachedFill", 128'(fillSeen), 128'(1));
    #2 reset = 1'b1;
    #1;
    checkOutput("rstFill memRdDrop", 128'(memRd), 128'(0));
    checkOutput("rstFill flags",
                128'({l2Ready, writeVerified, wbVerified, cacheHit, cacheMiss, memRd, memWr}), 128'(0));
    checkOutput("rstFill memAddr", 128'(memAddr), 128'(0));
    readReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    extra = '{K_READ, 1'b0, 32'h0000_0050, 32'h0, '0, B8, 0, 0, 32'h0, '0, 1, 32'h0000_0050, B8};
    applyStimulus("postReset0x50", extra);
    extra = '{K_READ, 1'b0, 32'h0000_0430, 32'h0, '0, B9, 0, 0, 32'h0, '0, 1, 32'h0000_0430, B9};
    applyStimulus("postResetDirtyCleared", extra);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
